uart_echo_top: RTL and testbench

//  Board-level UART transceiver top for a 100 MHz FPGA board: receives 8N1 serial bytes on

---
 rtl/uart_echo_if.sv | 10 +
 rtl/uart_echo_top.sv | 163 ++++++++++++++++
 tb/tb_uart_echo_top.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_if.sv
// rtl/uart_echo_if.sv - board pin bundle (switches, LEDs, UART lines) for uart_echo_top
interface uart_echo_if;
  logic [15:0] SW;
  logic        UART_TXD_IN;
  logic        UART_RXD_OUT;
  logic [15:0] LED;

  modport master (output SW, output UART_TXD_IN, input UART_RXD_OUT, input LED);
  modport slave  (input SW, input UART_TXD_IN, output UART_RXD_OUT, output LED);
endinterface

// File: rtl/uart_echo_top.sv
// rtl/uart_echo_top.sv - 8N1 UART receive/echo top with 1-byte pending buffer and sticky status LEDs
// Optional UARTRTX_RXCOUNT_EN: LED[13:8] counts valid received bytes mod 64.
module uart_echo_top #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  uart_echo_if.slave pins
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rx_meta, rx_sync;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, ferr;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, pend_byte;
  logic          txd, pend_full, ovf;
  logic          tx_free;
  logic [7:0]    new_byte;
  logic          sw_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= pins.UART_TXD_IN;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            // a start bit that is high again at mid-bit was a glitch
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        S_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end else ferr <= 1'b1;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // last cycle of the stop bit counts as free so a waiting byte follows with no idle gap
  assign tx_free  = (tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == BIT_LAST);
  assign new_byte = pins.SW[15] ? pins.SW[7:0] : rx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      txd       <= 1'b1;
      pend_full <= 1'b0;
      pend_byte <= '0;
      ovf       <= 1'b0;
    end else begin
      case (tx_state)
        S_START: txd <= 1'b0;
        S_DATA:  txd <= tx_shift[0];
        default: txd <= 1'b1;
      endcase
      if (tx_free) begin
        tx_cnt <= '0;
        if (pend_full) begin
          tx_shift  <= pend_byte;
          tx_state  <= S_START;
          pend_full <= rx_valid;
          if (rx_valid) pend_byte <= new_byte;
        end else if (rx_valid) begin
          tx_shift <= new_byte;
          tx_state <= S_START;
        end else tx_state <= S_IDLE;
      end else begin
        if (rx_valid) begin
          if (!pend_full) begin
            pend_full <= 1'b1;
            pend_byte <= new_byte;
          end else ovf <= 1'b1;
        end
        if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          case (tx_state)
            S_START: begin
              tx_bit   <= '0;
              tx_state <= S_DATA;
            end
            S_DATA: begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
              if (tx_bit == 3'd7) tx_state <= S_STOP;
            end
            default: tx_state <= S_IDLE;
          endcase
        end else tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  assign sw_unused         = ^pins.SW[14:8];
  assign pins.UART_RXD_OUT = txd;

`ifdef UARTRTX_RXCOUNT_EN
  logic [5:0] rx_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_count <= '0;
    else if (rx_valid) rx_count <= rx_count + 6'd1;
  end

  assign pins.LED = {ferr, ovf, rx_count, rx_byte};
`else
  assign pins.LED = {ferr, ovf, 6'd0, rx_byte};
`endif
endmodule

// File: tb/tb_uart_echo_top.sv
// tb/tb_uart_echo_top.sv - scoreboard bench for uart_echo_top (echo, SW override, glitch, framing, overflow)
`timescale 1ns/1ps
module tb_uart_echo_top;
  localparam int CLK_HZ     = 100_000_000;
  localparam int BAUD       = 1_000_000;
  localparam int CPB        = CLK_HZ / BAUD;
  localparam int HALF       = CPB / 2;
  localparam int SHORT_STOP = HALF + 8;
  localparam int FRAME_T    = 10 * CPB;
  localparam int FRAME_S    = 9 * CPB + SHORT_STOP;
  localparam int NSTREAM    = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_echo_if pins();

  uart_echo_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (.clk(clk), .rst(rst), .pins(pins));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int stop_neg;
  logic mon_en;
  logic mon_busy = 1'b0;
  logic [7:0] mon_byte;
  int mon_t0;
  logic [7:0] exp_q[$];
  int start_q[$];

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    pins.UART_TXD_IN = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
    stop_neg = ncyc;
    drive_bits(stop, stop_len);
    pins.UART_TXD_IN = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < budget), 1);
  endtask

  // serial decoder on the echo line
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mon_en && pins.UART_RXD_OUT === 1'b0) begin
        mon_busy = 1'b1;
        mon_t0   = ncyc;
        repeat (HALF) @(negedge clk);
        check("tx_start_bit", pins.UART_RXD_OUT, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = pins.UART_RXD_OUT;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", pins.UART_RXD_OUT, 1);
        start_q.push_back(mon_t0);
        if (exp_q.size() == 0) check("tx_frame_expected", exp_q.size(), 1);
        else check("tx_byte", mon_byte, exp_q.pop_front());
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] led_save;
    int lat_ref;
    longint free_t;
    bit pend;
    logic [7:0] pend_b, bj;
    int t;

    pins.SW = 16'h00FF;
    pins.UART_TXD_IN = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_led", pins.LED, 0);
    check("rst_txd", pins.UART_RXD_OUT, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xFD with a short stop, then 0xFF straight after: 0xFF waits in the pending buffer
    start_q.delete();
    exp_q.push_back(8'hFD);
    exp_q.push_back(8'hFF);
    send_frame(8'hFD, 1'b1, SHORT_STOP);
    lat_ref = stop_neg;
    check("led_fd", pins.LED[7:0], 8'hFD);
    send_frame(8'hFF, 1'b1, CPB);
    wait_drain(4 * FRAME_T);
    check("echo_frames", start_q.size(), 2);
    if (start_q.size() >= 2) begin
      check("echo_latency", start_q[0] - lat_ref, HALF + 5);
      check("back_to_back_gap", start_q[1] - start_q[0], FRAME_T);
    end
    check("led_ff", pins.LED[7:0], 8'hFF);
    check("led_err_flags", pins.LED[15:14], 0);

    // switch override
    pins.SW = 16'h80A5;
    exp_q.push_back(8'hA5);
    send_frame(8'h3C, 1'b1, CPB);
    check("led_3c", pins.LED[7:0], 8'h3C);
    wait_drain(3 * FRAME_T);
    repeat (CPB) @(negedge clk);

    // short low pulse is not a start bit
    start_q.delete();
    led_save = pins.LED;
    drive_bits(1'b0, CPB / 4);
    drive_bits(1'b1, 3 * CPB);
    check("glitch_led", pins.LED, led_save);
    check("glitch_txd", pins.UART_RXD_OUT, 1);

    // framing error
    send_frame(8'h5A, 1'b0, SHORT_STOP);
    repeat (3 * CPB) @(negedge clk);
    check("ferr_flag", pins.LED[15], 1);
    check("ferr_led_byte", pins.LED[7:0], 8'h3C);
    check("ferr_no_tx", start_q.size(), 0);

    // asynchronous reset in the middle of an outgoing all-zero frame
    mon_en = 1'b0;
    pins.SW = 16'h0000;
    send_frame(8'h00, 1'b1, CPB);
    repeat (3 * CPB) @(negedge clk);
    check("tx_low_before_rst", pins.UART_RXD_OUT, 0);
    #2 rst = 1'b1;
    #1 check("async_rst_txd", pins.UART_RXD_OUT, 1);
    check("async_rst_led", pins.LED, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;

    // stream of short-stop frames outruns the transmitter; frame-level model of the buffer
    start_q.delete();
    free_t = -100000;
    pend = 1'b0;
    pend_b = '0;
    for (int j = 0; j < NSTREAM; j++) begin
      t = j * FRAME_S + 1;
      bj = 8'(8'h20 + j);
      if (pend && free_t <= t) begin
        exp_q.push_back(pend_b);
        pend = 1'b0;
        free_t = free_t + FRAME_T;
      end
      if (free_t <= t) begin
        exp_q.push_back(bj);
        free_t = t + FRAME_T;
      end else if (!pend) begin
        pend = 1'b1;
        pend_b = bj;
      end
    end
    if (pend) exp_q.push_back(pend_b);
    for (int j = 0; j < NSTREAM; j++)
      send_frame(8'(8'h20 + j), 1'b1, (j == NSTREAM - 1) ? CPB : SHORT_STOP);
    wait_drain(4 * FRAME_T);
    check("ovf_flag", pins.LED[14], 1);
    check("ovf_no_ferr", pins.LED[15], 0);
    check("stream_last_led", pins.LED[7:0], 8'(8'h20 + NSTREAM - 1));
`ifdef UARTRTX_RXCOUNT_EN
    check("rx_count", pins.LED[13:8], NSTREAM % 64);
`else
    check("rx_count_off", pins.LED[13:8], 0);
`endif
    check("line_idle_end", pins.UART_RXD_OUT, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
